// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates two write requesters onto the single write port of a 16 x 16-bit
// register file, and can zero-fill the whole register file on request.
//
// The register file writes one cycle after a grant. rf_enable and rf_data_in
// are registered here, and the register file consumes them at the next edge.
// A zero-fill sweep writes registers 0..15 on 16 consecutive cycles. While the
// sweep runs, both requesters are held off.
//
// Ports
//   clk          system clock; all state changes on its rising edge
//   reset        synchronous, active-high reset
//   req0_valid   requester 0 holds a write request
//   req0_addr    requester 0 target register index
//   req0_data    requester 0 write data
//   req0_ready   combinational grant to requester 0 for this cycle
//   req1_valid   requester 1 holds a write request
//   req1_addr    requester 1 target register index
//   req1_data    requester 1 write data
//   req1_ready   combinational grant to requester 1 for this cycle
//   clear_start  one-cycle pulse that starts a zero-fill sweep
//   clear_busy   high while the zero-fill sweep runs
//   rf_enable    registered enable; 5'b10000 = idle, 5'b0_aaaa = write reg aaaa
//   rf_data_in   registered write data for the register file
//   write_count  number of committed requester writes (wraps)
//
// Build option
//   REGFILE_ARB_ROUND_ROBIN_EN  when defined, contention between the two
//                               requesters alternates (round robin). When it
//                               is undefined, requester 0 always wins.
// -----------------------------------------------------------------------------
module regfile_write_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [3:0]  req0_addr,
   input  logic [15:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [3:0]  req1_addr,
   input  logic [15:0] req1_data,
   output logic        req1_ready,
   input  logic        clear_start,
   output logic        clear_busy,
   output logic [4:0]  rf_enable,
   output logic [15:0] rf_data_in,
   output logic [15:0] write_count
);

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [3:0]  cnt_r;
   logic [3:0]  cnt_next_s;
   logic        grant0_s;
   logic        grant1_s;
   logic        xfer0_s;
   logic        xfer1_s;
   logic [4:0]  enable_next_s;
   logic [15:0] data_next_s;
   logic [15:0] count_next_s;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
   // High when requester 1 should win the next contention.
   logic        prio1_r;
   logic        prio1_next_s;
`endif

   // Grants never escape while reset is asserted.
   assign req0_ready = grant0_s & ~reset;
   assign req1_ready = grant1_s & ~reset;
   assign clear_busy = (state_r == SWEEP) & ~reset;

   assign xfer0_s = req0_valid & req0_ready;
   assign xfer1_s = req1_valid & req1_ready;

   // Next-state, sweep counter and grant selection.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      grant0_s     = 1'b0;
      grant1_s     = 1'b0;
      case (state_r)
         ARB: begin
            if (clear_start) begin
               // A clear request beats both requesters in this cycle.
               state_next_s = SWEEP;
               cnt_next_s   = 4'd0;
            end else if (req0_valid && req1_valid) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
               grant0_s = ~prio1_r;
               grant1_s = prio1_r;
`else
               grant0_s = 1'b1;
               grant1_s = 1'b0;
`endif
            end else if (req0_valid) begin
               grant0_s = 1'b1;
            end else if (req1_valid) begin
               grant1_s = 1'b1;
            end else begin
               grant0_s = 1'b0;
               grant1_s = 1'b0;
            end
         end
         SWEEP: begin
            // cnt_r wraps from 15 to 0 while the state returns to ARB.
            cnt_next_s = cnt_r + 4'd1;
            if (cnt_r == 4'd15) begin
               state_next_s = ARB;
            end else begin
               state_next_s = SWEEP;
            end
         end
         default: begin
            state_next_s = ARB;
            cnt_next_s   = 4'd0;
         end
      endcase
   end

   // Register-file write port and committed-write counter next values.
   always_comb begin
      enable_next_s = 5'b10000;
      data_next_s   = rf_data_in;
      count_next_s  = write_count;
      if (xfer0_s) begin
         enable_next_s = {1'b0, req0_addr};
         data_next_s   = req0_data;
         count_next_s  = write_count + 16'd1;
      end else if (xfer1_s) begin
         enable_next_s = {1'b0, req1_addr};
         data_next_s   = req1_data;
         count_next_s  = write_count + 16'd1;
      end else if (state_r == SWEEP) begin
         enable_next_s = {1'b0, cnt_r};
         data_next_s   = 16'h0000;
      end else begin
         enable_next_s = 5'b10000;
         data_next_s   = rf_data_in;
      end
   end

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
   // The round-robin pointer moves only when a transfer actually happens.
   always_comb begin
      prio1_next_s = prio1_r;
      if (xfer0_s) begin
         prio1_next_s = 1'b1;
      end else if (xfer1_s) begin
         prio1_next_s = 1'b0;
      end else begin
         prio1_next_s = prio1_r;
      end
   end

   // Round-robin pointer register; requester 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio1_r <= 1'b0;
      end else begin
         prio1_r <= prio1_next_s;
      end
   end
`endif

   // State, sweep counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ARB;
         cnt_r       <= 4'd0;
         rf_enable   <= 5'b10000;
         rf_data_in  <= 16'h0000;
         write_count <= 16'h0000;
      end else begin
         state_r     <= state_next_s;
         cnt_r       <= cnt_next_s;
         rf_enable   <= enable_next_s;
         rf_data_in  <= data_next_s;
         write_count <= count_next_s;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter. It starts with a table of
// single-cycle vectors, then runs hand-written sequences for the zero-fill
// sweep, reset during a sweep, idle hold and write_count wrap. A behavioural
// 16 x 16 register file is driven from rf_enable and rf_data_in so that the
// register contents can be compared after each sweep.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0;
   logic [3:0]  req0_addr = 4'd0;
   logic [15:0] req0_data = 16'h0000;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [3:0]  req1_addr = 4'd0;
   logic [15:0] req1_data = 16'h0000;
   logic        req1_ready;
   logic        clear_start = 1'b0;
   logic        clear_busy;
   logic [4:0]  rf_enable;
   logic [15:0] rf_data_in;
   logic [15:0] write_count;

   always #5 clk = ~clk;

   regfile_write_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_addr   (req0_addr),
      .req0_data   (req0_data),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_addr   (req1_addr),
      .req1_data   (req1_data),
      .req1_ready  (req1_ready),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .rf_enable   (rf_enable),
      .rf_data_in  (rf_data_in),
      .write_count (write_count)
   );

   // Behavioural register file driven by the arbiter.
   logic [15:0] rf_mem [16];
   always @(posedge clk) begin
      if (rf_enable[4] == 1'b0) rf_mem[rf_enable[3:0]] <= rf_data_in;
   end

   typedef struct {
      logic        rst;
      logic        v0;
      logic [3:0]  a0;
      logic [15:0] d0;
      logic        v1;
      logic [3:0]  a1;
      logic [15:0] d1;
      logic        clr;
      logic        r0;     // expected req0_ready
      logic        r1;     // expected req1_ready
      logic        busy;   // expected clear_busy
      logic        swp;    // a sweep write is expected at this edge
      logic [3:0]  idx;    // register index of that sweep write
   } vec_t;

   typedef struct {
      logic [4:0]  en;
      logic [15:0] data;
      logic [15:0] wc;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad = 0;
   logic [15:0] exp_data_hold = 16'h0000;
   logic [15:0] exp_wc = 16'h0000;
   logic [15:0] exp_mem [16];
   vec_t        tbl [11];

   function automatic vec_t mk(input logic rst, input logic v0, input logic [3:0] a0,
                               input logic [15:0] d0, input logic v1, input logic [3:0] a1,
                               input logic [15:0] d1, input logic clr, input logic r0,
                               input logic r1, input logic busy, input logic swp,
                               input logic [3:0] idx);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.clr = clr; v.r0 = r0; v.r1 = r1; v.busy = busy; v.swp = swp; v.idx = idx;
      return v;
   endfunction

   function automatic vec_t idle_v();
      return mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, check the combinational grants, and check the registered outputs after the edge.
   task automatic apply(input vec_t v);
      exp_t e;
      reset       = v.rst;
      req0_valid  = v.v0;
      req0_addr   = v.a0;
      req0_data   = v.d0;
      req1_valid  = v.v1;
      req1_addr   = v.a1;
      req1_data   = v.d1;
      clear_start = v.clr;
      @(negedge clk);
      check("req0_ready", 32'(req0_ready), 32'(v.r0));
      check("req1_ready", 32'(req1_ready), 32'(v.r1));
      check("clear_busy", 32'(clear_busy), 32'(v.busy));
      if (v.rst) begin
         e.en = 5'b10000; e.data = 16'h0000; exp_wc = 16'h0000;
      end else if (v.r0) begin
         e.en = {1'b0, v.a0}; e.data = v.d0; exp_wc = exp_wc + 16'd1;
      end else if (v.r1) begin
         e.en = {1'b0, v.a1}; e.data = v.d1; exp_wc = exp_wc + 16'd1;
      end else if (v.swp) begin
         e.en = {1'b0, v.idx}; e.data = 16'h0000;
      end else begin
         e.en = 5'b10000; e.data = exp_data_hold;
      end
      exp_data_hold = e.data;
      e.wc = exp_wc;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("rf_enable", 32'(rf_enable), 32'(e.en));
      check("rf_data_in", 32'(rf_data_in), 32'(e.data));
      check("write_count", 32'(write_count), 32'(e.wc));
   endtask

   task automatic check_mem(input string tag);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("%s reg%0d", tag, i), 32'(rf_mem[i]), 32'(exp_mem[i]));
      end
   endtask

   initial begin
      // Reset with every request input active, then basic grants and contention.
      tbl[0]  = mk(1'b1, 1'b1, 4'd9, 16'h9999, 1'b1, 4'd8, 16'h8888, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      tbl[1]  = mk(1'b0, 1'b1, 4'd3, 16'h00A5, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tbl[2]  = idle_v();
      tbl[3]  = mk(1'b1, 1'b1, 4'd3, 16'h0BAD, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      tbl[4]  = mk(1'b0, 1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tbl[5]  = mk(1'b0, 1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, !RR,  RR,   1'b0, 1'b0, 4'd0);
      tbl[6]  = mk(1'b0, 1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tbl[7]  = mk(1'b0, 1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, !RR,  RR,   1'b0, 1'b0, 4'd0);
      tbl[8]  = mk(1'b0, 1'b1, 4'd4, 16'h0444, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      tbl[9]  = mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      tbl[10] = idle_v();
      for (int i = 0; i < 11; i++) apply(tbl[i]);

      // Zero-fill sweep with req1 waiting, plus a stray clear_start mid-sweep.
      for (int i = 0; i < 16; i++) begin
         apply(mk(1'b0, 1'b1, 4'(i), 16'hA000 + 16'(i), 1'b0, 4'd0, 16'h0000, 1'b0,
                  1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
         exp_mem[i] = 16'hA000 + 16'(i);
      end
      apply(mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'h5555, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      for (int k = 0; k < 16; k++) begin
         apply(mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'h5555, (k == 3),
                  1'b0, 1'b0, 1'b1, 1'b1, 4'(k)));
      end
      apply(mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'h5555, 1'b0,
               1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
      apply(idle_v());
      for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0000;
      exp_mem[5] = 16'h5555;
      check_mem("sweep");

      // Reset during the sweep cycle with counter 6; registers 6-15 keep their values.
      for (int i = 0; i < 16; i++) begin
         apply(mk(1'b0, 1'b1, 4'(i), 16'hB000 + 16'(i), 1'b0, 4'd0, 16'h0000, 1'b0,
                  1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
         exp_mem[i] = 16'hB000 + 16'(i);
      end
      apply(mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      for (int k = 0; k < 6; k++) begin
         apply(mk(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0,
                  1'b0, 1'b0, 1'b1, 1'b1, 4'(k)));
         exp_mem[k] = 16'h0000;
      end
      apply(mk(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      apply(idle_v());
      check_mem("abort");

      // Ten idle cycles leave the register file untouched.
      for (int i = 0; i < 10; i++) apply(idle_v());
      check_mem("idle");

      // write_count wrap: 65535 transfers reach 16'hFFFF, and one more wraps to 0.
      apply(mk(1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
      reset      = 1'b0;
      req0_valid = 1'b1;
      req0_addr  = 4'd0;
      req0_data  = 16'h1234;
      repeat (65535) @(posedge clk);
      #1;
      check("wrap preload count", 32'(write_count), 32'h0000FFFF);
      check("wrap preload enable", 32'(rf_enable), 32'h00000000);
      exp_wc        = 16'hFFFF;
      exp_data_hold = 16'h1234;
      apply(mk(1'b0, 1'b1, 4'd0, 16'h4321, 1'b0, 4'd0, 16'h0000, 1'b0,
               1'b1, 1'b0, 1'b0, 1'b0, 4'd0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
